// File: rtl/io_led_pwm_pkg.sv
// Shared definitions for the io_led_pwm LED port: command opcodes, the
// command-decoder state encoding and the bfcpu I/O write-direction value.
`ifndef DIRECTION_WRITE
`define DIRECTION_WRITE 1'b1
`endif

package io_led_pwm_pkg;

   localparam logic IO_DIR_WRITE = `DIRECTION_WRITE;

   localparam logic [2:0] IO_LED_OP_SEL  = 3'b100;
   localparam logic [2:0] IO_LED_OP_DUTY = 3'b101;
   localparam logic [2:0] IO_LED_OP_ALL  = 3'b110;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DATA_ONE = 2'd1,
      DATA_ALL = 2'd2
   } io_led_state_e;

endpackage

// File: rtl/io_led_pwm_channel.sv
// One PWM LED channel: holds the written duty (target) and produces the
// registered LED bit by comparing the running PWM count with the duty.
// With IO_LED_PWM_FADE_EN defined, the compare uses a separate actual duty
// that walks one step toward the target on every PWM counter wrap.
module io_led_pwm_channel #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [PWM_BITS-1:0] wdata,
   input  logic [PWM_BITS-1:0] cnt,
   input  logic                wrap,
   output logic                led,
   output logic [PWM_BITS-1:0] target
);

   localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

   logic [PWM_BITS-1:0] actual;

   // Written duty; this is also what reads return.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        target <= '0;
      else if (wr_en) target <= wdata;
   end

`ifdef IO_LED_PWM_FADE_EN
   // Fade: actual duty steps once per PWM period toward the target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         actual <= '0;
      end else if (wrap) begin
         if (actual < target)      actual <= actual + 1'b1;
         else if (actual > target) actual <= actual - 1'b1;
      end
   end
`else
   logic unused_wrap;
   assign unused_wrap = wrap;
   assign actual      = target;
`endif

   // Full-scale duty forces the LED solidly on instead of one dark count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) led <= 1'b0;
      else     led <= (cnt < actual) || (actual == DUTY_FULL);
   end

endmodule

// File: rtl/io_led_pwm.sv
// io_led_pwm: bfcpu io_* byte port driving CHANNELS PWM LEDs.
// Bytes with bit 7 clear are legacy on/off writes; otherwise the top three
// bits select SEL / SET_DUTY / SET_ALL, the latter two taking a data byte.
// Optional fade build: define IO_LED_PWM_FADE_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | next write is a legacy byte or a command
//   DATA_ONE | next write is the duty for the selected channel
//   DATA_ALL | next write is the duty for every channel
module io_led_pwm
   import io_led_pwm_pkg::*;
#(
   parameter int CHANNELS = 3,
   parameter int PWM_BITS = 8,
   parameter int PRESCALE = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                io_req,
   input  logic                io_dir,
   input  logic [7:0]          io_wdata,
   output logic                io_ack,
   output logic [7:0]          io_rdata,
   output logic [CHANNELS-1:0] led
);

   localparam int                  PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(PRESCALE - 1);
   localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

   io_led_state_e       state_q, state_d;
   logic [2:0]          sel_q, sel_d;
   logic [PS_W-1:0]     ps_q;
   logic [PWM_BITS-1:0] cnt_q;
   logic                accept, is_write, step, wrap;
   logic                wr_legacy, wr_one, wr_all;
   logic [PWM_BITS-1:0] duty_pad [8];

   assign accept   = io_req && !io_ack;
   assign is_write = (io_dir == IO_DIR_WRITE);
   assign step     = (ps_q == PS_LAST);
   assign wrap     = step && (cnt_q == DUTY_FULL);

   // Handshake, command state, channel select and read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io_ack   <= 1'b0;
         io_rdata <= '0;
         state_q  <= IDLE;
         sel_q    <= '0;
      end else begin
         io_ack  <= accept;
         state_q <= state_d;
         sel_q   <= sel_d;
         if (accept && !is_write) io_rdata <= 8'(duty_pad[sel_q]);
      end
   end

   // Command decode; reads never change state, so a pending data byte survives them.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      wr_legacy = 1'b0;
      wr_one    = 1'b0;
      wr_all    = 1'b0;
      if (accept && is_write) begin
         case (state_q)
            IDLE: begin
               if (!io_wdata[7]) begin
                  wr_legacy = 1'b1;
               end else begin
                  case (io_wdata[7:5])
                     IO_LED_OP_SEL:  if (io_wdata[3:0] < 4'(CHANNELS)) sel_d = io_wdata[2:0];
                     IO_LED_OP_DUTY: state_d = DATA_ONE;
                     IO_LED_OP_ALL:  state_d = DATA_ALL;
                     default:        ;
                  endcase
               end
            end
            DATA_ONE: begin
               wr_one  = 1'b1;
               state_d = IDLE;
            end
            DATA_ALL: begin
               wr_all  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Prescaler and free-running PWM counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps_q  <= '0;
         cnt_q <= '0;
      end else begin
         ps_q <= step ? '0 : ps_q + 1'b1;
         if (step) cnt_q <= cnt_q + 1'b1;
      end
   end

   // Read mux is padded to 8 entries so the 3-bit select indexes it exactly.
   for (genvar g = 0; g < 8; g++) begin : g_ch
      if (g < CHANNELS) begin : g_on
         logic                we;
         logic [PWM_BITS-1:0] wd;
         assign we = wr_legacy || wr_all || (wr_one && (sel_q == 3'(g)));
         assign wd = wr_legacy ? (io_wdata[g] ? DUTY_FULL : '0) : io_wdata[PWM_BITS-1:0];

         io_led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_channel (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (we),
            .wdata  (wd),
            .cnt    (cnt_q),
            .wrap   (wrap),
            .led    (led[g]),
            .target (duty_pad[g])
         );
      end else begin : g_off
         assign duty_pad[g] = '0;
      end
   end

endmodule

// File: doc/io_led_pwm.md
Name: io_led_pwm

Overview:
- Parametrised successor to the on-chip LED I/O port. Attaches to the bfcpu io_* byte handshake.
- Drives CHANNELS LED outputs, each with PWM_BITS-bit brightness, instead of plain on/off bits.
- A small byte-stream command protocol selects and writes channels.
- Legacy raw writes remain compatible: a write with bit 7 clear sets LEDs fully on or off.

Parameters:
- CHANNELS, 3, number of LED outputs; range 1..7.
- PWM_BITS, 8, duty/counter width; range 1..8.
- PRESCALE, 1, clocks per PWM counter step; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- io_req  in  1  CPU I/O request.
- io_dir  in  1  direction; DIRECTION_WRITE = write, otherwise read.
- io_wdata  in  8  write byte.
- io_ack  out  1  one-cycle acknowledge.
- io_rdata  out  8  read byte; valid in the cycle io_ack is high.
- led  out  CHANNELS  active-high PWM outputs, registered.

Behaviour:
- Reset values (asynchronous): io_ack=0, io_rdata=0, led=0, all duty=0, sel=0, state=IDLE, prescaler=0, pwm counter=0.
- Handshake:
  - A request is accepted when io_req=1 and io_ack=0.
  - io_ack rises the next cycle and holds for exactly 1 cycle.
  - A request held high is re-accepted every 2 cycles.
  - All side effects happen on the accepting edge.
- Write decode, state IDLE:
  - wdata[7]=0 (legacy): for each channel i, duty[i] = all-ones if wdata[i]=1, else 0.
  - wdata[7:5]=3'b100, SEL: sel ← wdata[3:0] if it is < CHANNELS; otherwise sel is unchanged. Stay in IDLE.
  - wdata[7:5]=3'b101, SET_DUTY: go to DATA_ONE.
  - wdata[7:5]=3'b110, SET_ALL: go to DATA_ALL.
  - wdata[7:5]=3'b111: ignored; still acked.
- State DATA_ONE: on the next write, duty[sel] ← wdata[PWM_BITS-1:0]; go to IDLE.
- State DATA_ALL: on the next write, every duty ← wdata[PWM_BITS-1:0]; go to IDLE.
- Reads:
  - Acked in any state; state is unchanged.
  - io_rdata ← zero-extended duty[sel], registered on the accepting edge.
  - In DATA_* states a read does not consume the pending data byte.
- PWM timing:
  - The prescaler counts 0..PRESCALE-1.
  - The PWM counter increments when the prescaler wraps, and wraps from all-ones to 0.
  - Period = PRESCALE·2^PWM_BITS clocks.
- PWM output:
  - led[i] registered as (cnt < duty[i]) OR (duty[i] == all-ones).
  - So duty=0 is always off and duty=all-ones is always on.
  - Latency from a duty write to the led change is ≤ 1 PWM period + 1 clock.
- Simultaneous events: a duty write in the same cycle as a counter wrap takes effect from the following compare.
- Reset mid-command: a DATA_* state is abandoned and returns to IDLE.

Optional Feature:
- Macro: IO_LED_PWM_FADE_EN.
- Defined:
  - Each channel keeps a target (the written value) and an actual duty that drives the compare.
  - On every PWM counter wrap, actual moves 1 step toward target.
  - Legacy writes and SET_* writes set the target only.
  - Reads return the target.
  - Reset clears both.
- Undefined: actual ≡ target, with no fade logic.

Decomposition:
- Shared package/header holds:
  - opcode constants IO_LED_OP_SEL=3'b100, IO_LED_OP_DUTY=3'b101, IO_LED_OP_ALL=3'b110;
  - state encoding (IDLE, DATA_ONE, DATA_ALL);
  - DIRECTION_WRITE, reused from the existing direction macros.
- Sub-module io_led_pwm_channel, instanced per channel:
  - inputs: clk, rst, wr_en, wdata[PWM_BITS-1:0], cnt, wrap;
  - output: led bit;
  - contains the duty register and the fade logic.

Test Plan:
- Reset then legacy write 8'h05, CHANNELS=3, PRESCALE=1 → io_ack pulses 1 cycle; led[0] and led[2] are constantly 1; led[1]=0; read returns 8'hFF while sel=0.
- Write 8'h81 then 8'hA0 then 8'h40 → duty[1]=64; led[1] is high for exactly 64 of every 256 clocks; read returns 8'h40.
- Write 8'hC0 then 8'h00 → all led stay 0 for ≥2 full periods. Write 8'h87 (SEL out of range) → sel unchanged; read still returns the prior channel's duty.
- Write 8'hA0, then a read, then 8'h80 → read returns old duty, state is unchanged, and the second write sets duty[sel]=8'h80.
- Hold io_req high for 10 cycles doing writes → io_ack pattern 0101010101; exactly 5 writes take effect. Assert rst while in DATA_ONE → state IDLE, all outputs 0 immediately.
- IO_LED_PWM_FADE_EN defined, PWM_BITS=4, write duty 0→15 → actual duty reaches 15 after exactly 15 PWM wraps; read returns 15 immediately.
